// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan driver: segment patterns ({g,f,e,d,c,b,a}),
// the scan-slot type and the slot index of each displayed digit.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [1:0] slot_t;

  localparam slot_t DIG_HI_TENS = 2'd0;
  localparam slot_t DIG_HI_ONES = 2'd1;
  localparam slot_t DIG_LO_TENS = 2'd2;
  localparam slot_t DIG_LO_ONES = 2'd3;

  // Slot 0 drives the leftmost digit, which sits on enable bit 3.
  function automatic logic [3:0] slot_onehot(slot_t slot);
    return 4'b1000 >> slot;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver with per-frame snapshot, dead time and blanking.
// Define SEVSEG_BRIGHTNESS_EN to add the brightness_i PWM dimming input.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
`ifdef SEVSEG_BRIGHTNESS_EN
  input  logic [2:0] brightness_i,
`endif
  input  logic [3:0] hi_tens_i,
  input  logic [3:0] hi_ones_i,
  input  logic [3:0] lo_tens_i,
  input  logic [3:0] lo_ones_i,
  input  logic       colon_i,
  input  logic       lzb_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [3:0] dig_en_o,
  output logic       frame_o
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  slot_t           slot_q, slot_d;
  logic [3:0][3:0] snap_q, snap_d;
  logic            colon_q, colon_d;
  logic [6:0]      seg_d;
  logic            dp_d, frame_d;
  logic [3:0]      dig_en_d;

  logic       slot_end, frame_end, live, pwm_on, lz_blank, en;
  logic [6:0] dec_seg;

  assign slot_end  = (cnt_q == CntLast);
  assign frame_end = slot_end && (slot_q == DIG_LO_ONES);

  if (BLANK_CYCLES == 0) begin : g_no_dead
    assign live = 1'b1;
  end else begin : g_dead
    assign live = (cnt_q >= CntW'(BLANK_CYCLES));
  end

`ifdef SEVSEG_BRIGHTNESS_EN
  logic [2:0] pwm_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 3'd1;
    end
  end

  assign pwm_on = (pwm_cnt_q <= brightness_i);
`else
  assign pwm_on = 1'b1;
`endif

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (snap_q[slot_q]),
    .seg_o (dec_seg)
  );

  // lzb_i is deliberately live; only the digit value comes from the snapshot.
  assign lz_blank = (slot_q == DIG_HI_TENS) && lzb_i && (snap_q[DIG_HI_TENS] == 4'd0);
  assign en       = live && pwm_on && !lz_blank;

  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    slot_d  = slot_end ? slot_q + 2'd1 : slot_q;
    snap_d  = snap_q;
    colon_d = colon_q;
    if (frame_end) begin
      snap_d[DIG_HI_TENS] = hi_tens_i;
      snap_d[DIG_HI_ONES] = hi_ones_i;
      snap_d[DIG_LO_TENS] = lo_tens_i;
      snap_d[DIG_LO_ONES] = lo_ones_i;
      colon_d             = colon_i;
    end

    dig_en_d = en ? slot_onehot(slot_q) : 4'b0000;
    seg_d    = en ? dec_seg : SEG_BLANK;
    dp_d     = en && (slot_q == DIG_HI_ONES) && colon_q;
    frame_d  = frame_end;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      slot_q   <= DIG_HI_TENS;
      snap_q   <= '0;
      colon_q  <= 1'b0;
      seg_o    <= SEG_BLANK;
      dp_o     <= 1'b0;
      dig_en_o <= 4'b0000;
      frame_o  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      snap_q   <= snap_d;
      colon_q  <= colon_d;
      seg_o    <= seg_d;
      dp_o     <= dp_d;
      dig_en_o <= dig_en_d;
      frame_o  <= frame_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scan_driver;

  localparam int unsigned ScanDiv  = 8;
  localparam int unsigned Blank    = 2;
  localparam int unsigned FrameLen = 4 * ScanDiv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ht, ho, lt, lo;
  logic       colon, lzb;
  logic [2:0] brightness = 3'd7;
  logic [6:0] seg;
  logic       dp, frame;
  logic [3:0] dig;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .SCAN_DIV     (ScanDiv),
    .BLANK_CYCLES (Blank)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
`ifdef SEVSEG_BRIGHTNESS_EN
    .brightness_i (brightness),
`endif
    .hi_tens_i    (ht),
    .hi_ones_i    (ho),
    .lo_tens_i    (lt),
    .lo_ones_i    (lo),
    .colon_i      (colon),
    .lzb_i        (lzb),
    .seg_o        (seg),
    .dp_o         (dp),
    .dig_en_o     (dig),
    .frame_o      (frame)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       fr;
  } obs_t;

  obs_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned e;
  logic [3:0]  m_snap[4];
  logic        m_colon;
  int          fr_seen, d3_seen;

  function automatic logic [6:0] seg_of(logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs after edge e derive from cycle index e: cnt = e%8, slot = (e/8)%4.
  task automatic cycle();
    obs_t        x, o;
    int unsigned cnt, slot;
    logic        blank;
    @(posedge clk);
    if (!rst) begin
      cnt   = e % ScanDiv;
      slot  = (e / ScanDiv) % 4;
      blank = (slot == 0) && lzb && (m_snap[0] == 4'd0);
      x     = '0;
      if (cnt >= Blank && !blank) begin
        x.dig = 4'(4'b1000 >> slot);
        x.seg = seg_of(m_snap[slot]);
        x.dp  = (slot == 1) && m_colon;
      end
      x.fr = ((e % FrameLen) == FrameLen - 1);
      if (x.fr) begin
        m_snap  = '{ht, ho, lt, lo};
        m_colon = colon;
      end
      sb_q.push_back(x);
      e++;
    end
    #1;
    if (!rst) begin
      o = {seg, dp, dig, frame};
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        x = sb_q.pop_front();
        check($sformatf("out@%0d", e), 32'(o), 32'(x));
      end
      if (frame)  fr_seen++;
      if (dig[3]) d3_seen++;
    end
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic model_reset();
    e       = 0;
    m_snap  = '{default: 4'd0};
    m_colon = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    ht = 4'd0; ho = 4'd0; lt = 4'd0; lo = 4'd0;
    colon = 1'b0; lzb = 1'b0;
    fr_seen = 0; d3_seen = 0;
    model_reset();

    #12;
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_dig", 32'(dig), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Scan order over three frames; the first shows the zero reset snapshot.
    ht = 4'd1; ho = 4'd2; lt = 4'd3; lo = 4'd4;
    run(96);
    check("frame_pulses", 32'(fr_seen), 32'd3);
    check("dig3_cycles", 32'(d3_seen), 32'd18);

    // Tearing: new inputs mid slot 1 must wait for the next frame.
    run(12);
    ht = 4'd5; ho = 4'd6; lt = 4'd7; lo = 4'd8;
    run(52);

    // Leading-zero blanking and colon.
    ht = 4'd0; lzb = 1'b1; colon = 1'b1;
    run(64);

    // Non-BCD digit.
    lzb = 1'b0; colon = 1'b0; lo = 4'hC;
    run(64);

    // Asynchronous reset in the middle of slot 2.
    run(20);
    #2 rst = 1'b1;
    #1;
    check("async_seg", 32'(seg), 32'd0);
    check("async_dp", 32'(dp), 32'd0);
    check("async_dig", 32'(dig), 32'd0);
    check("async_frame", 32'(frame), 32'd0);
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed 4-digit 7-segment display driver; sits directly downstream of the two BCD counters, hours/minutes or minutes/seconds. Snapshots four BCD digits plus a colon flag once per frame, so the display never tears mid-frame. Decodes each digit to segments and scans the digit enables one at a time, with dead time between digits to prevent ghosting. All outputs are registered and drive the pads directly.

## Interface
- `SCAN_DIV`, 1000: clock cycles per digit slot; legal range ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, 4: dead cycles at the start of each slot; `dig_en_o` is all-zero during these cycles. Legal range ≥ 0.

- `clk_i` input 1: clock; single clock domain.
- `rst_i` input 1: reset, asynchronous, active-high.
- `hi_tens_i` input 4: BCD, leftmost digit.
- `hi_ones_i` input 4: BCD, second digit.
- `lo_tens_i` input 4: BCD, third digit.
- `lo_ones_i` input 4: BCD, rightmost digit.
- `colon_i` input 1: colon/decimal point shown on the `hi_ones` digit.
- `lzb_i` input 1: leading-zero blanking of `hi_tens` when it equals 0.
- `seg_o` output 7: {g,f,e,d,c,b,a}, active-high.
- `dp_o` output 1: decimal point, active-high.
- `dig_en_o` output 4: one-hot or zero digit enable, active-high. Bit 3 = `hi_tens`, bit 0 = `lo_ones`.
- `frame_o` output 1: one-cycle pulse when a new snapshot is taken.

## Operation
- State:
  - `cnt` runs 0..`SCAN_DIV`-1 and wraps.
  - `slot` runs 0..3; it advances when `cnt` = `SCAN_DIV`-1 and wraps 3→0.
  - Snapshot registers hold 4×4 BCD digits plus colon.
- Snapshot:
  - Loaded when `slot`=3 and `cnt`=`SCAN_DIV`-1 (frame boundary).
  - `frame_o` pulses high in the following cycle.
  - Input changes at any other time have no effect until the next boundary.
- Slot mapping:
  - slot 0 → `dig_en_o`[3], `hi_tens`
  - slot 1 → [2], `hi_ones`
  - slot 2 → [1], `lo_tens`
  - slot 3 → [0], `lo_ones`
- Digit enable: `dig_en_o` = 0 while `cnt` < `BLANK_CYCLES`; otherwise the slot's bit is set.
- Decode:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Non-BCD values 10–15 decode to 0x40 ("-").
- Blanking: in slot 0, if `lzb_i`=1 and snapshot `hi_tens`=0, then `seg_o`=0 and `dig_en_o` stays 0 for the whole slot. `lzb_i` is sampled live.
- Decimal point: `dp_o` = snapshot colon during slot 1 outside the dead time; 0 otherwise.
- `seg_o` and `dp_o` are forced to 0 whenever `dig_en_o` is 0.

## Timing
- All outputs are registered: outputs in cycle n+1 reflect (`slot`, `cnt`, snapshot) of cycle n.
- Reset values:
  - `cnt`=0, `slot`=0, snapshot=0.
  - `seg_o`=0, `dp_o`=0, `dig_en_o`=0, `frame_o`=0.
- First frame after reset displays the reset snapshot (zeros). The first input-driven frame starts at cycle 4·`SCAN_DIV`+1 after reset release.
- Reset asserted mid-frame: all outputs go to 0 immediately (asynchronously). The scan restarts at slot 0, `cnt` 0.
- Slot transition: the last enabled cycle of slot k is followed by `BLANK_CYCLES` cycles of `dig_en_o`=0. With `BLANK_CYCLES`=0, the enable moves directly to the next bit with no gap and never has two bits set.
- Snapshot load and slot 3→0 wrap occur in the same cycle. Slot 0 always uses the new snapshot.

## Configuration
- `SEVSEG_BRIGHTNESS_EN` defined:
  - Adds input `brightness_i` [2:0] and a free-running 3-bit `pwm_cnt` (reset 0, increments every cycle).
  - Outside the dead time, the digit is enabled only when `pwm_cnt` ≤ `brightness_i`, giving a duty of (`brightness_i`+1)/8.
  - `brightness_i`=7 is identical to the macro undefined.
  - `brightness_i` is sampled live.
- `SEVSEG_BRIGHTNESS_EN` undefined: no port and no PWM counter; the digit is enabled for the whole non-dead portion of the slot.

## Structure
- Package `seven_seg_pkg`:
  - Segment constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`.
  - 2-bit slot typedef.
  - Digit-index constants.
- Sub-module `bcd_to_seg`: combinational 4-bit → 7-bit decoder, instantiated once on the muxed snapshot digit.

## Test plan
Bench parameters: `SCAN_DIV`=8, `BLANK_CYCLES`=2, macro undefined unless stated.
- Scan order: inputs 1,2,3,4, `lzb_i`=0, run 3 frames.
  - Second frame shows `dig_en_o` 1000/0100/0010/0001, each high for 6 cycles with 2 zero cycles between.
  - `seg_o` = 0x06, 0x5B, 0x4F, 0x66 respectively.
- Tearing: change the inputs from 1,2,3,4 to 5,6,7,8 in mid slot 1.
  - The remainder of the frame still shows 2,3,4.
  - The next frame shows 0x6D, 0x7D, 0x07, 0x7F.
  - `frame_o` pulses once per 32 cycles.
- Blanking and colon: `hi_tens_i`=0, `lzb_i`=1, `colon_i`=1.
  - Slot 0: `dig_en_o`=0 and `seg_o`=0 for all 8 cycles.
  - Slot 1: `dp_o`=1 exactly while `dig_en_o`=0100.
- Invalid BCD: `lo_ones_i`=4'hC → slot 3 `seg_o`=0x40.
- Reset: assert `rst_i` asynchronously mid slot 2 → all outputs 0 the same cycle. After release, slot 0 restarts with snapshot 0 (`seg_o`=0x3F when `lzb_i`=0).
- Brightness: macro defined, `brightness_i`=1 → within each slot, `dig_en_o` is high only on cycles where `pwm_cnt` ∈ {0,1} and `cnt` ≥ 2.
